// File: rtl/decode_stage.sv
// Decode stage: splits the fetched instruction into fields, reads operands with writeback bypass,
// tracks in-flight register writers, and stalls fetch on data hazards and unresolved branches.
module decode_stage #(
    parameter int          PC_WIDTH   = 16,
    parameter int          IR_WIDTH   = 32,
    parameter int          DATA_WIDTH = 16,
    parameter int          NUM_REGS   = 16,
    parameter logic [7:0]  OP_NOP     = 8'hFF,
    parameter logic [3:0]  BR_CLASS   = 4'hB,
    parameter logic [3:0]  ST_CLASS   = 4'hA
) (
    input  logic                  I_CLOCK,
    input  logic                  I_LOCK,
    input  logic [PC_WIDTH-1:0]   I_PC,
    input  logic [IR_WIDTH-1:0]   I_IR,
    input  logic                  I_FE_Valid,
    input  logic                  I_WB_Valid,
    input  logic [3:0]            I_WB_DestReg,
    input  logic [DATA_WIDTH-1:0] I_WB_Data,
    input  logic                  I_BranchResolved,
    output logic                  O_LOCK,
    output logic [PC_WIDTH-1:0]   O_PC,
    output logic [7:0]            O_Opcode,
    output logic [3:0]            O_DestReg,
    output logic [DATA_WIDTH-1:0] O_Src1Value,
    output logic [DATA_WIDTH-1:0] O_Src2Value,
    output logic [15:0]           O_Imm,
    output logic                  O_DE_Valid,
    output logic                  O_DepStallSignal,
    output logic                  O_BranchStallSignal
);

    typedef enum logic {BR_IDLE, BR_PENDING} br_state_t;

    br_state_t br_state_q, br_state_d;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [1:0]            busy_q [NUM_REGS];

    logic                  lock_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [7:0]            opcode_q;
    logic [3:0]            dest_q;
    logic [DATA_WIDTH-1:0] src1_val_q, src2_val_q;
    logic [15:0]           imm_q;
    logic                  de_valid_q;

    logic [7:0]            opcode;
    logic [3:0]            dest, src1, src2;
    logic                  is_nop, is_br, is_st, writes_dest, reads_src2;
    logic                  src1_hazard, src2_hazard, dep_stall, issue;
    logic [DATA_WIDTH-1:0] src1_val, src2_val;

    assign opcode      = I_IR[31:24];
    assign dest        = I_IR[23:20];
    assign src1        = I_IR[19:16];
    assign src2        = I_IR[11:8];
    assign is_nop      = (opcode == OP_NOP);
    assign is_br       = (opcode[7:4] == BR_CLASS);
    assign is_st       = (opcode[7:4] == ST_CLASS);
    assign writes_dest = ~is_nop & ~is_br & ~is_st;
    assign reads_src2  = ~is_br;

    // A single outstanding writer that retires this cycle is not a hazard; its data is forwarded.
    assign src1_hazard = (busy_q[src1] != 2'd0) &&
                         !(busy_q[src1] == 2'd1 && I_WB_Valid && I_WB_DestReg == src1);
    assign src2_hazard = (busy_q[src2] != 2'd0) &&
                         !(busy_q[src2] == 2'd1 && I_WB_Valid && I_WB_DestReg == src2);
    assign src1_val    = (I_WB_Valid && I_WB_DestReg == src1) ? I_WB_Data : regs_q[src1];
    assign src2_val    = (I_WB_Valid && I_WB_DestReg == src2) ? I_WB_Data : regs_q[src2];

    assign dep_stall = I_LOCK & I_FE_Valid & ~is_nop & (src1_hazard | (reads_src2 & src2_hazard));
    assign issue     = I_FE_Valid & ~dep_stall & (br_state_q == BR_IDLE) & ~is_nop;

    always_comb begin
        br_state_d = br_state_q;
        case (br_state_q)
            BR_IDLE:    if (issue && is_br) br_state_d = BR_PENDING;
            BR_PENDING: if (I_BranchResolved) br_state_d = BR_IDLE;
            default:    br_state_d = BR_IDLE;
        endcase
    end

    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) br_state_q <= BR_IDLE;
        else         br_state_q <= br_state_d;
    end

    // Register file and busy counters, one slice per architectural register.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic inc, dec;
            assign inc = issue & writes_dest & (dest == 4'(gi));
            assign dec = I_WB_Valid & (I_WB_DestReg == 4'(gi));

            always_ff @(negedge I_CLOCK) begin
                if (!I_LOCK) begin
                    regs_q[gi] <= '0;
                    busy_q[gi] <= 2'd0;
                end else begin
                    if (dec) regs_q[gi] <= I_WB_Data;
                    if (inc && !dec && busy_q[gi] != 2'd3)      busy_q[gi] <= busy_q[gi] + 2'd1;
                    else if (dec && !inc && busy_q[gi] != 2'd0) busy_q[gi] <= busy_q[gi] - 2'd1;
                end
            end
        end
    endgenerate

    always_ff @(negedge I_CLOCK) begin
        lock_q <= I_LOCK;
    end

    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) begin
            pc_q       <= '0;
            opcode_q   <= OP_NOP;
            dest_q     <= 4'd0;
            src1_val_q <= '0;
            src2_val_q <= '0;
            imm_q      <= 16'd0;
            de_valid_q <= 1'b0;
        end else if (issue) begin
            pc_q       <= I_PC;
            opcode_q   <= opcode;
            dest_q     <= dest;
            src1_val_q <= src1_val;
            src2_val_q <= src2_val;
            imm_q      <= I_IR[15:0];
            de_valid_q <= 1'b1;
        end else begin
            // Bubble: only the opcode and valid change, the rest of the latch holds.
            opcode_q   <= OP_NOP;
            de_valid_q <= 1'b0;
        end
    end

    assign O_LOCK              = lock_q;
    assign O_PC                = pc_q;
    assign O_Opcode            = opcode_q;
    assign O_DestReg           = dest_q;
    assign O_Src1Value         = src1_val_q;
    assign O_Src2Value         = src2_val_q;
    assign O_Imm               = imm_q;
    assign O_DE_Valid          = de_valid_q;
    assign O_DepStallSignal    = dep_stall;
    assign O_BranchStallSignal = (br_state_q == BR_PENDING);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: inputs change 1 time unit after each negedge,
// registered outputs are checked 1 unit after the negedge, the combinational stall 1 unit after inputs settle.
module tb_decode_stage;

    logic        I_CLOCK = 1'b1;
    logic        I_LOCK;
    logic [15:0] I_PC;
    logic [31:0] I_IR;
    logic        I_FE_Valid;
    logic        I_WB_Valid;
    logic [3:0]  I_WB_DestReg;
    logic [15:0] I_WB_Data;
    logic        I_BranchResolved;
    logic        O_LOCK;
    logic [15:0] O_PC;
    logic [7:0]  O_Opcode;
    logic [3:0]  O_DestReg;
    logic [15:0] O_Src1Value;
    logic [15:0] O_Src2Value;
    logic [15:0] O_Imm;
    logic        O_DE_Valid;
    logic        O_DepStallSignal;
    logic        O_BranchStallSignal;

    int checks   = 0;
    int failures = 0;

    decode_stage dut (
        .I_CLOCK            (I_CLOCK),
        .I_LOCK             (I_LOCK),
        .I_PC               (I_PC),
        .I_IR               (I_IR),
        .I_FE_Valid         (I_FE_Valid),
        .I_WB_Valid         (I_WB_Valid),
        .I_WB_DestReg       (I_WB_DestReg),
        .I_WB_Data          (I_WB_Data),
        .I_BranchResolved   (I_BranchResolved),
        .O_LOCK             (O_LOCK),
        .O_PC               (O_PC),
        .O_Opcode           (O_Opcode),
        .O_DestReg          (O_DestReg),
        .O_Src1Value        (O_Src1Value),
        .O_Src2Value        (O_Src2Value),
        .O_Imm              (O_Imm),
        .O_DE_Valid         (O_DE_Valid),
        .O_DepStallSignal   (O_DepStallSignal),
        .O_BranchStallSignal(O_BranchStallSignal)
    );

    always #5 I_CLOCK = ~I_CLOCK;

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [3:0] d,
                                       input logic [3:0] s1, input logic [3:0] s2,
                                       input logic [7:0] lo);
        return {op, d, s1, 4'h0, s2, lo};
    endfunction

    task automatic tick();
        @(negedge I_CLOCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [15:0] pc, input logic [31:0] ir);
        I_PC       = pc;
        I_IR       = ir;
        I_FE_Valid = 1'b1;
    endtask

    task automatic wb(input logic [3:0] r, input logic [15:0] d);
        I_WB_Valid   = 1'b1;
        I_WB_DestReg = r;
        I_WB_Data    = d;
    endtask

    initial begin
        I_LOCK = 1'b0; I_PC = '0; I_IR = mk(8'hFF, 4'd0, 4'd0, 4'd0, 8'h00);
        I_FE_Valid = 1'b0; I_WB_Valid = 1'b0; I_WB_DestReg = '0; I_WB_Data = '0;
        I_BranchResolved = 1'b0;

        // Reset held for two cycles
        tick(); tick();
        check("rst_lock",     32'(O_LOCK), 0);
        check("rst_opcode",   32'(O_Opcode), 32'hFF);
        check("rst_valid",    32'(O_DE_Valid), 0);
        check("rst_pc",       32'(O_PC), 0);
        check("rst_dest",     32'(O_DestReg), 0);
        check("rst_src1",     32'(O_Src1Value), 0);
        check("rst_src2",     32'(O_Src2Value), 0);
        check("rst_imm",      32'(O_Imm), 0);
        check("rst_brstall",  32'(O_BranchStallSignal), 0);
        I_LOCK = 1'b1;
        #1 check("lock_pre",  32'(O_LOCK), 0);
        tick();
        check("lock_post",    32'(O_LOCK), 1);
        check("idle_valid",   32'(O_DE_Valid), 0);

        // Preload r2=5, r3=7
        wb(4'd2, 16'd5); tick();
        wb(4'd3, 16'd7); tick();
        I_WB_Valid = 1'b0;

        // ADD r1,r2,r3
        fetch(16'h0010, mk(8'h00, 4'd1, 4'd2, 4'd3, 8'h45));
        #1 check("add1_dep", 32'(O_DepStallSignal), 0);
        tick();
        check("add1_valid",   32'(O_DE_Valid), 1);
        check("add1_opcode",  32'(O_Opcode), 32'h00);
        check("add1_pc",      32'(O_PC), 32'h0010);
        check("add1_dest",    32'(O_DestReg), 1);
        check("add1_src1",    32'(O_Src1Value), 5);
        check("add1_src2",    32'(O_Src2Value), 7);
        check("add1_imm",     32'(O_Imm), 32'h0345);

        // ADD r4,r1,r1 waits on r1
        fetch(16'h0014, mk(8'h00, 4'd4, 4'd1, 4'd1, 8'h00));
        #1 check("raw_dep1", 32'(O_DepStallSignal), 1);
        tick();
        check("raw_bubble1",  32'(O_DE_Valid), 0);
        check("raw_nop1",     32'(O_Opcode), 32'hFF);
        check("raw_pc_hold",  32'(O_PC), 32'h0010);
        check("raw_dest_hold",32'(O_DestReg), 1);
        check("raw_dep2",     32'(O_DepStallSignal), 1);
        tick();
        check("raw_bubble2",  32'(O_DE_Valid), 0);
        wb(4'd1, 16'd9);
        #1 check("raw_bypass_dep", 32'(O_DepStallSignal), 0);
        tick();
        I_WB_Valid = 1'b0;
        check("raw_valid",    32'(O_DE_Valid), 1);
        check("raw_dest",     32'(O_DestReg), 4);
        check("raw_src1",     32'(O_Src1Value), 9);
        check("raw_src2",     32'(O_Src2Value), 9);
        check("raw_pc",       32'(O_PC), 32'h0014);

        // Branch reads src1 only (src2 field names busy r4)
        fetch(16'h0020, mk(8'hB0, 4'd7, 4'd2, 4'd4, 8'h10));
        #1 check("br_dep", 32'(O_DepStallSignal), 0);
        tick();
        check("br_valid",     32'(O_DE_Valid), 1);
        check("br_opcode",    32'(O_Opcode), 32'hB0);
        check("br_stall",     32'(O_BranchStallSignal), 1);
        fetch(16'h0024, mk(8'h00, 4'd6, 4'd2, 4'd3, 8'h00));
        #1 check("brp_dep", 32'(O_DepStallSignal), 0);
        tick();
        check("brp_block1",   32'(O_DE_Valid), 0);
        check("brp_stall1",   32'(O_BranchStallSignal), 1);
        tick();
        check("brp_block2",   32'(O_DE_Valid), 0);
        I_BranchResolved = 1'b1;
        tick();
        I_BranchResolved = 1'b0;
        check("br_resolved",  32'(O_BranchStallSignal), 0);
        check("br_res_valid", 32'(O_DE_Valid), 0);
        tick();
        check("post_br_valid",32'(O_DE_Valid), 1);
        check("post_br_dest", 32'(O_DestReg), 6);
        check("post_br_src1", 32'(O_Src1Value), 5);
        check("post_br_src2", 32'(O_Src2Value), 7);

        // Branch must not have marked r7 busy
        fetch(16'h0028, mk(8'h00, 4'd8, 4'd7, 4'd2, 8'h00));
        #1 check("br_nodest_dep", 32'(O_DepStallSignal), 0);
        tick();
        check("br_nodest_valid", 32'(O_DE_Valid), 1);

        // Four writers to r5 saturate its counter at 3
        fetch(16'h0030, mk(8'h00, 4'd5, 4'd2, 4'd3, 8'h00));
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("sat_issue%0d", i), 32'(O_DE_Valid), 1);
        end
        fetch(16'h0034, mk(8'h00, 4'd9, 4'd5, 4'd2, 8'h00));
        #1 check("sat_dep", 32'(O_DepStallSignal), 1);
        tick();
        check("sat_bubble",   32'(O_DE_Valid), 0);
        wb(4'd5, 16'h0011);
        #1 check("wb_cnt3_dep", 32'(O_DepStallSignal), 1);
        tick();
        #1 check("wb_cnt2_dep", 32'(O_DepStallSignal), 1);
        tick();
        #1 check("wb_cnt1_dep", 32'(O_DepStallSignal), 0);
        tick();
        I_WB_Valid = 1'b0;
        check("sat_valid",    32'(O_DE_Valid), 1);
        check("sat_src1",     32'(O_Src1Value), 32'h11);
        check("sat_src2",     32'(O_Src2Value), 5);
        fetch(16'h0038, mk(8'h00, 4'd10, 4'd5, 4'd5, 8'h00));
        #1 check("r5_free_dep", 32'(O_DepStallSignal), 0);
        tick();
        check("r5_free_src1", 32'(O_Src1Value), 32'h11);

        // Store reads src2 (busy r6) and writes no destination
        fetch(16'h003C, mk(8'hA0, 4'd11, 4'd2, 4'd6, 8'h00));
        #1 check("st_dep", 32'(O_DepStallSignal), 1);
        tick();
        check("st_bubble",    32'(O_DE_Valid), 0);
        wb(4'd6, 16'h0033);
        #1 check("st_bypass_dep", 32'(O_DepStallSignal), 0);
        tick();
        I_WB_Valid = 1'b0;
        check("st_valid",     32'(O_DE_Valid), 1);
        check("st_opcode",    32'(O_Opcode), 32'hA0);
        check("st_src1",      32'(O_Src1Value), 5);
        check("st_src2",      32'(O_Src2Value), 32'h33);
        fetch(16'h0040, mk(8'h00, 4'd12, 4'd11, 4'd11, 8'h00));
        #1 check("st_nodest_dep", 32'(O_DepStallSignal), 0);
        tick();
        check("st_nodest_valid", 32'(O_DE_Valid), 1);

        // NOP never stalls or issues
        fetch(16'h0044, mk(8'hFF, 4'd0, 4'd4, 4'd4, 8'h00));
        #1 check("nop_dep", 32'(O_DepStallSignal), 0);
        tick();
        check("nop_valid",    32'(O_DE_Valid), 0);
        check("nop_opcode",   32'(O_Opcode), 32'hFF);

        // Reset with a branch pending and r2 counter at 2
        fetch(16'h0050, mk(8'h00, 4'd2, 4'd3, 4'd3, 8'h00));
        tick(); tick();
        fetch(16'h0054, mk(8'hB0, 4'd0, 4'd3, 4'd3, 8'h00));
        tick();
        check("mid_brstall",  32'(O_BranchStallSignal), 1);
        fetch(16'h0058, mk(8'h00, 4'd13, 4'd2, 4'd2, 8'h00));
        #1 check("mid_dep", 32'(O_DepStallSignal), 1);
        I_LOCK = 1'b0;
        #1 check("mid_dep_lock", 32'(O_DepStallSignal), 0);
        tick();
        check("mid_rst_brstall", 32'(O_BranchStallSignal), 0);
        check("mid_rst_valid",   32'(O_DE_Valid), 0);
        check("mid_rst_lock",    32'(O_LOCK), 0);
        check("mid_rst_pc",      32'(O_PC), 0);
        I_LOCK = 1'b1;
        #1 check("mid_cnt_clear", 32'(O_DepStallSignal), 0);
        tick();
        check("mid_issue_valid", 32'(O_DE_Valid), 1);
        check("mid_issue_dest",  32'(O_DestReg), 13);
        check("mid_issue_src1",  32'(O_Src1Value), 0);
        check("mid_issue_src2",  32'(O_Src2Value), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of fetch. Consumes the fetch latch (PC, IR, valid) and decodes the instruction.
- Reads the 16-entry register file and tracks in-flight writers with a per-register scoreboard.
- Drives two stall signals back to fetch: dependency stall and branch stall. Produces the decode→execute latch.
- The register file is written from the writeback port.

Parameters:
PC_WIDTH, 16, program counter width
IR_WIDTH, 32, instruction width
DATA_WIDTH, 16, register data width
NUM_REGS, 16, architectural registers (4-bit specifiers)
OP_NOP, 8'hFF, bubble opcode inserted by fetch
BR_CLASS, 4'hB, opcode[7:4] value marking branch/jump
ST_CLASS, 4'hA, opcode[7:4] value marking store (no destination write)

Ports:
I_CLOCK  in  1  clock; all state updates on negedge
I_LOCK  in  1  synchronous active-low reset, sampled on negedge (0 = reset)
I_PC  in  PC_WIDTH  PC from fetch latch
I_IR  in  IR_WIDTH  instruction from fetch latch
I_FE_Valid  in  1  fetch latch valid
I_WB_Valid  in  1  writeback write enable
I_WB_DestReg  in  4  writeback register index
I_WB_Data  in  DATA_WIDTH  writeback data
I_BranchResolved  in  1  branch target resolved downstream (same cycle as fetch's branch-address select)
O_LOCK  out  1  I_LOCK delayed one negedge
O_PC  out  PC_WIDTH  latched PC
O_Opcode  out  8  latched opcode
O_DestReg  out  4  latched destination
O_Src1Value  out  DATA_WIDTH  operand 1
O_Src2Value  out  DATA_WIDTH  operand 2
O_Imm  out  16  IR[15:0]
O_DE_Valid  out  1  decode latch valid
O_DepStallSignal  out  1  combinational; to fetch
O_BranchStallSignal  out  1  registered; to fetch

Behaviour:
Field decode from I_IR:
- opcode = IR[31:24], dest = IR[23:20], src1 = IR[19:16], src2 = IR[11:8].
- Writes-dest = not NOP, not BR_CLASS, not ST_CLASS.
- Branches read src1 only. Stores read src1 and src2.

Reset (I_LOCK=0 at negedge):
- O_PC=0, O_Opcode=OP_NOP, O_DestReg=0, O_Src*Value=0, O_Imm=0, O_DE_Valid=0.
- branch_pending=0. All scoreboard counters=0. All registers=0.
- Reset mid-operation discards all in-flight state.
- O_LOCK<=I_LOCK on every negedge, including during reset.

Scoreboard:
- 2-bit busy counter per register; saturates at 3 and never goes below 0.
- Issue of a writes-dest instruction increments counter[dest].
- I_WB_Valid decrements counter[I_WB_DestReg].
- Issue and writeback to the same register in the same cycle: net unchanged.

Hazard (combinational):
- src_hazard(r) = counter[r]!=0, except no hazard when counter[r]==1 and I_WB_Valid and I_WB_DestReg==r.
- In the bypass case the operand value is I_WB_Data.
- O_DepStallSignal = I_LOCK & I_FE_Valid & (opcode!=OP_NOP) & (src_hazard on any read source).

Register file:
- Written on negedge when I_WB_Valid.
- Read is combinational, with the writeback bypass above.

Issue (negedge, I_LOCK=1):
- Issue condition: I_FE_Valid & ~O_DepStallSignal & ~branch_pending & opcode!=OP_NOP.
  - When true: latch all decode outputs and set O_DE_Valid=1.
  - When false: O_DE_Valid=0 and O_Opcode=OP_NOP; other outputs hold.
- A dependency stall emits a bubble each cycle. Fetch holds its latch, so the same IR is re-evaluated each cycle until the hazard clears.

Branch state machine (IDLE/PENDING):
- IDLE→PENDING on issue of a BR_CLASS instruction.
- PENDING→IDLE on I_BranchResolved.
- O_BranchStallSignal = (state==PENDING).
- While PENDING, no instruction issues, whatever I_FE_Valid is.
- I_BranchResolved while IDLE is ignored.
- Issue of a branch and I_BranchResolved in the same cycle: the result is PENDING (the new branch wins).

Latency: one negedge from fetch latch to decode latch when no stall.

Test Plan:
- Hold I_LOCK=0 for 2 cycles, then release → all outputs at reset values; O_LOCK follows I_LOCK one negedge later; O_Opcode=8'hFF.
- Issue `ADD r1,r2,r3` (opcode 8'h00, regs preloaded via WB r2=5, r3=7) → next negedge O_DE_Valid=1, O_DestReg=1, O_Src1Value=5, O_Src2Value=7; counter[r1]=1.
- Back-to-back `ADD r1,...` then `ADD r4,r1,r1` → O_DepStallSignal=1 and O_DE_Valid=0 each cycle until WB r1=9 arrives. In the WB cycle the stall drops (bypass) and the second instruction issues with Src1=Src2=9.
- Branch (opcode 8'hB0) issue → O_BranchStallSignal=1 from the next negedge. Valid fetch inputs are ignored (O_DE_Valid=0) until I_BranchResolved, then the stall clears on that negedge.
- Three writers to r5 with no writeback → counter=3. A fourth writer → still 3. Three WB r5 → counter=0 and no hazard.
- Assert I_LOCK=0 while branch pending and counter[r2]=2 → after one negedge the stall signals are 0 and all counters are 0.
